pulse_conditioner: RTL and testbench

//  Multi-channel pulse conditioner: turns raw level/pulse inputs into clean output pulses.
//  One conditioning mode per channel: single edge pulse, alternate-cycle toggle, holdoff or stretch.

---
 rtl/pulse_cond_pkg.sv | 13 +
 rtl/pulse_conditioner_if.sv | 23 ++
 rtl/pulse_cond_ch.sv | 100 ++++++++++
 rtl/pulse_conditioner.sv | 42 ++++
 tb/tb_pulse_conditioner.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pulse_cond_pkg.sv
// Shared types for the pulse conditioner: per-channel mode encoding.
package pulse_cond_pkg;

    localparam int PC_MODE_W = 2;

    typedef enum logic [PC_MODE_W-1:0] {
        PC_EDGE    = 2'd0,
        PC_TOGGLE  = 2'd1,
        PC_HOLDOFF = 2'd2,
        PC_STRETCH = 2'd3
    } pc_mode_e;

endpackage

// File: rtl/pulse_conditioner_if.sv
// Control/status bundle of the pulse conditioner. Master drives controls and
// raw pulses; slave (the conditioner) returns conditioned pulses and drop counts.
interface pulse_conditioner_if #(
    parameter int N_CH   = 4,
    parameter int DROP_W = 8
);
    logic                     en;
    logic [2*N_CH-1:0]        mode;
    logic [N_CH-1:0]          pulse_in;
    logic                     drop_clr;
    logic [N_CH-1:0]          pulse_out;
    logic [N_CH*DROP_W-1:0]   drop_cnt;

    modport master (
        output en, mode, pulse_in, drop_clr,
        input  pulse_out, drop_cnt
    );

    modport slave (
        input  en, mode, pulse_in, drop_clr,
        output pulse_out, drop_cnt
    );
endinterface

// File: rtl/pulse_cond_ch.sv
// One conditioning channel: edge detect, mode-specific output shaping and a
// saturating count of edges suppressed while in holdoff.
module pulse_cond_ch
    import pulse_cond_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int HOLDOFF_CYC = 16,
    parameter int STRETCH_CYC = 4,
    parameter int DROP_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  pc_mode_e          mode,
    input  logic              pulse_in,
    input  logic              drop_clr,
    output logic              pulse_out,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLDOFF_CYC);
    localparam logic [CNT_W-1:0]  STR_LD   = CNT_W'(STRETCH_CYC - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic             prev;
    logic             tog;
    logic [CNT_W-1:0] cnt;
    pc_mode_e         mode_q;

    logic rise;
    logic mode_chg;
    logic cnt_zero;
    logic drop_evt;

    assign rise     = pulse_in & ~prev;
    assign mode_chg = (mode != mode_q);
    assign cnt_zero = (cnt == '0);
    assign drop_evt = en && !mode_chg && (mode_q == PC_HOLDOFF) && rise && !cnt_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= 1'b0;
            tog       <= 1'b0;
            cnt       <= '0;
            mode_q    <= PC_EDGE;
            pulse_out <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // prev keeps tracking while disabled so a held input gives no pulse on re-enable
            prev   <= pulse_in;
            mode_q <= mode;

            if (drop_clr)
                drop_cnt <= '0;
            else if (drop_evt && drop_cnt != DROP_MAX)
                drop_cnt <= drop_cnt + DROP_W'(1);

            if (!en || mode_chg) begin
                pulse_out <= 1'b0;
                cnt       <= '0;
                tog       <= 1'b0;
            end else begin
                case (mode_q)
                    PC_EDGE: begin
                        pulse_out <= rise;
                    end
                    PC_TOGGLE: begin
                        pulse_out <= pulse_in & ~tog;
                        if (pulse_in)
                            tog <= ~tog;
                    end
                    PC_HOLDOFF: begin
                        if (rise && cnt_zero) begin
                            pulse_out <= 1'b1;
                            cnt       <= HOLD_LD;
                        end else begin
                            pulse_out <= 1'b0;
                            if (!cnt_zero)
                                cnt <= cnt - CNT_W'(1);
                        end
                    end
                    PC_STRETCH: begin
                        // a new edge retriggers the full stretch window
                        if (rise) begin
                            pulse_out <= 1'b1;
                            cnt       <= STR_LD;
                        end else if (!cnt_zero) begin
                            pulse_out <= 1'b1;
                            cnt       <= cnt - CNT_W'(1);
                        end else begin
                            pulse_out <= 1'b0;
                        end
                    end
                    default: pulse_out <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/pulse_conditioner.sv
// Multi-channel pulse conditioner: N_CH independent channels sharing only
// clock, reset, enable and the drop-counter clear.
module pulse_conditioner
    import pulse_cond_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int HOLDOFF_CYC = 16,
    parameter int STRETCH_CYC = 4,
    parameter int DROP_W      = 8
) (
    input logic                 clk,
    input logic                 reset,
    pulse_conditioner_if.slave  bus
);

    if (HOLDOFF_CYC < 1 || HOLDOFF_CYC > (2**CNT_W) - 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYC must lie in 1..2^CNT_W-1");
    end
    if (STRETCH_CYC < 1 || STRETCH_CYC > (2**CNT_W) - 1) begin : g_bad_stretch
        $error("STRETCH_CYC must lie in 1..2^CNT_W-1");
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pulse_cond_ch #(
            .CNT_W       (CNT_W),
            .HOLDOFF_CYC (HOLDOFF_CYC),
            .STRETCH_CYC (STRETCH_CYC),
            .DROP_W      (DROP_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (bus.en),
            .mode      (pc_mode_e'(bus.mode[PC_MODE_W*gi +: PC_MODE_W])),
            .pulse_in  (bus.pulse_in[gi]),
            .drop_clr  (bus.drop_clr),
            .pulse_out (bus.pulse_out[gi]),
            .drop_cnt  (bus.drop_cnt[DROP_W*gi +: DROP_W])
        );
    end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner: ch0 EDGE, ch1 TOGGLE, ch2 HOLDOFF, ch3 STRETCH.
module tb_pulse_conditioner;
    import pulse_cond_pkg::*;

    localparam int N_CH   = 4;
    localparam int DROP_W = 2;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    pulse_conditioner_if #(.N_CH(N_CH), .DROP_W(DROP_W)) bus ();

    pulse_conditioner #(
        .N_CH        (N_CH),
        .CNT_W       (8),
        .HOLDOFF_CYC (16),
        .STRETCH_CYC (4),
        .DROP_W      (DROP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] drop2();
        return 32'(bus.drop_cnt[2*DROP_W +: DROP_W]);
    endfunction

    initial begin
        reset        = 1'b1;
        bus.en       = 1'b1;
        bus.mode     = {PC_STRETCH, PC_HOLDOFF, PC_TOGGLE, PC_EDGE};
        bus.pulse_in = '0;
        bus.drop_clr = 1'b0;
        step();
        step();
        chk("reset_pulse_out", 32'(bus.pulse_out), 32'd0);
        chk("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        reset = 1'b0;
        step();
        step();

        // EDGE: input high for 10 cycles gives one pulse, one cycle later
        for (int c = 0; c < 12; c++) begin
            bus.pulse_in[0] = (c < 10);
            chk($sformatf("edge_c%0d", c), 32'(bus.pulse_out[0]), 32'(c == 1));
            step();
        end

        // TOGGLE: held input gives 1,0,1,0,1,0
        for (int c = 0; c < 8; c++) begin
            bus.pulse_in[1] = (c < 6);
            chk($sformatf("toggle_c%0d", c), 32'(bus.pulse_out[1]),
                32'(c >= 1 && c <= 6 && (c % 2 == 1)));
            step();
        end
        // tog is held across a low input, so the second high cycle gives no pulse
        for (int c = 0; c < 4; c++) begin
            bus.pulse_in[1] = (c == 0 || c == 2);
            chk($sformatf("toggle_hold_c%0d", c), 32'(bus.pulse_out[1]), 32'(c == 1));
            step();
        end

        // HOLDOFF: edges at 0,5,10,17 -> pulses at 1 and 18, two drops
        for (int c = 0; c < 20; c++) begin
            bus.pulse_in[2] = (c == 0 || c == 5 || c == 10 || c == 17);
            chk($sformatf("holdoff_c%0d", c), 32'(bus.pulse_out[2]), 32'(c == 1 || c == 18));
            if (c == 6)  chk("holdoff_drop_1", drop2(), 32'd1);
            if (c == 19) chk("holdoff_drop_2", drop2(), 32'd2);
            step();
        end

        // STRETCH: single edge -> high 1..4; retrigger at 2 -> high 1..6
        for (int c = 0; c < 7; c++) begin
            bus.pulse_in[3] = (c == 0);
            chk($sformatf("stretch_c%0d", c), 32'(bus.pulse_out[3]), 32'(c >= 1 && c <= 4));
            step();
        end
        for (int c = 0; c < 9; c++) begin
            bus.pulse_in[3] = (c == 0 || c == 2);
            chk($sformatf("retrig_c%0d", c), 32'(bus.pulse_out[3]), 32'(c >= 1 && c <= 6));
            step();
        end

        repeat (20) step();

        // Saturation and clear priority on ch2
        bus.drop_clr = 1'b1;
        step();
        bus.drop_clr = 1'b0;
        chk("drop_clr_only", drop2(), 32'd0);
        for (int c = 0; c < 21; c++) begin
            bus.pulse_in[2] = (c <= 10 && (c % 2 == 0)) || (c == 14);
            bus.drop_clr    = (c == 12 || c == 14);
            chk($sformatf("sat_out_c%0d", c), 32'(bus.pulse_out[2]), 32'(c == 1));
            if (c == 12) chk("drop_saturated", drop2(), 32'd3);
            if (c == 13) chk("drop_cleared", drop2(), 32'd0);
            if (c == 15) chk("drop_clr_wins", drop2(), 32'd0);
            step();
        end
        bus.drop_clr    = 1'b0;
        bus.pulse_in[2] = 1'b0;
        step();

        // Asynchronous reset in the middle of a stretch and a holdoff
        bus.pulse_in[3] = 1'b1;
        bus.pulse_in[2] = 1'b1;
        step();
        bus.pulse_in[3] = 1'b0;
        bus.pulse_in[2] = 1'b0;
        chk("pre_reset_out", 32'(bus.pulse_out), 32'hC);
        step();
        bus.pulse_in[2] = 1'b1;
        chk("pre_reset_stretch", 32'(bus.pulse_out[3]), 32'd1);
        step();
        bus.pulse_in[2] = 1'b0;
        chk("pre_reset_drop", drop2(), 32'd1);
        chk("pre_reset_stretch_c3", 32'(bus.pulse_out[3]), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(bus.pulse_out), 32'd0);
        chk("async_reset_drop", 32'(bus.drop_cnt), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        bus.pulse_in[2] = 1'b1;
        step();
        bus.pulse_in[2] = 1'b0;
        chk("holdoff_after_reset", 32'(bus.pulse_out[2]), 32'd1);
        step();

        // en low: outputs forced low, stretch cut; held input gives no pulse on en rise
        bus.pulse_in[3] = 1'b1;
        step();
        bus.en          = 1'b0;
        bus.pulse_in[3] = 1'b0;
        bus.pulse_in[0] = 1'b1;
        chk("en_stretch_started", 32'(bus.pulse_out[3]), 32'd1);
        step();
        chk("en_low_forces_zero", 32'(bus.pulse_out), 32'd0);
        step();
        bus.en = 1'b1;
        chk("en_low_still_zero", 32'(bus.pulse_out), 32'd0);
        step();
        chk("en_rise_held_input", 32'(bus.pulse_out), 32'd0);
        step();
        bus.pulse_in[0] = 1'b0;
        chk("en_after_rise", 32'(bus.pulse_out), 32'd0);
        step();
        bus.pulse_in[0] = 1'b1;
        step();
        bus.pulse_in[0] = 1'b0;
        chk("en_new_edge", 32'(bus.pulse_out[0]), 32'd1);
        step();

        // Mode change: edge in the change cycle is ignored
        bus.mode[1:0]   = PC_STRETCH;
        bus.pulse_in[0] = 1'b1;
        step();
        bus.pulse_in[0] = 1'b0;
        chk("mode_chg_ignores_edge", 32'(bus.pulse_out[0]), 32'd0);
        step();
        bus.pulse_in[0] = 1'b1;
        step();
        bus.pulse_in[0] = 1'b0;
        chk("new_mode_stretch_c1", 32'(bus.pulse_out[0]), 32'd1);
        step();
        step();
        step();
        chk("new_mode_stretch_c4", 32'(bus.pulse_out[0]), 32'd1);
        step();
        chk("new_mode_stretch_end", 32'(bus.pulse_out[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
